// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and encodings for the 5-stage pipeline sequencer.
package pipe_ctrl_pkg;

  // stall[5:0] = {wb, mem, ex, id, if, pc}; a set bit holds that register
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  localparam logic [31:0] EXC_ERET = 32'h0000000e;

  typedef enum logic {
    RUN        = 1'b0,
    FLUSH_WAIT = 1'b1
  } pipe_state_e;

  typedef enum logic [1:0] {
    SRC_IF  = 2'd0,
    SRC_ID  = 2'd1,
    SRC_EX  = 2'd2,
    SRC_MEM = 2'd3
  } stall_src_e;

endpackage

// File: rtl/stall_watchdog.sv
// Continuous-stall watchdog: counts consecutive stalled cycles and raises a
// sticky timeout flag that only rst clears.
module stall_watchdog #(
  parameter int                   TIMEOUT_W     = 16,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_LIMIT = '1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_stall_active,
  input  logic i_flush,
  output logic o_timeout
);

  logic [TIMEOUT_W-1:0] r_cnt;
  logic [TIMEOUT_W-1:0] w_cnt_nxt;
  logic                 r_sticky;
  logic                 w_hit;
  logic                 w_count_en;

  assign w_count_en = i_stall_active && !i_flush;

  always_comb begin
    w_cnt_nxt = '0;
    if (w_count_en) begin
      w_cnt_nxt = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
    end
  end

  // The flag is visible in the very cycle whose stall brings the count to the limit
  assign w_hit     = w_count_en && (w_cnt_nxt == TIMEOUT_LIMIT);
  assign o_timeout = r_sticky | w_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_sticky <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_sticky <= r_sticky | w_hit;
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencer: merges stall requests, turns MEM exceptions into flush +
// redirect, holds the front end after a redirect. Optional PIPE_PERF_EN adds stall counters.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int                   TIMEOUT_W     = 16,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_LIMIT = 16'hFFFF,
  parameter logic [31:0]          EXC_VEC       = 32'h00000020,
  parameter int                   PERF_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_if,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              stallreq_mem,
  input  logic [31:0]       excepttype_i,
  input  logic [31:0]       cp0_epc_i,
  input  logic [1:0]        perf_sel,
  output logic [5:0]        stall,
  output logic              flush,
  output logic [31:0]       new_pc,
  output logic              stall_timeout,
  output logic [PERF_W-1:0] perf_cnt
);

  pipe_state_e r_state;
  pipe_state_e w_state_nxt;
  logic [5:0]  w_stall;
  logic        w_flush;
  logic [31:0] w_new_pc;
  logic        w_src_vld;
  stall_src_e  w_src;

  always_comb begin
    w_stall     = STALL_NONE;
    w_flush     = 1'b0;
    w_new_pc    = 32'h0;
    w_state_nxt = r_state;
    w_src_vld   = 1'b0;
    w_src       = SRC_IF;
    if (!rst) begin
      case (r_state)
        RUN: begin
          if (excepttype_i != 32'h0) begin
            w_flush  = 1'b1;
            w_new_pc = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VEC;
            // A fetch still in flight would land on the old path; wait it out
            if (stallreq_if) w_state_nxt = FLUSH_WAIT;
          end else if (stallreq_mem) begin
            w_stall   = STALL_MEM;
            w_src_vld = 1'b1;
            w_src     = SRC_MEM;
          end else if (stallreq_ex) begin
            w_stall   = STALL_EX;
            w_src_vld = 1'b1;
            w_src     = SRC_EX;
          end else if (stallreq_id) begin
            w_stall   = STALL_ID;
            w_src_vld = 1'b1;
            w_src     = SRC_ID;
          end else if (stallreq_if) begin
            w_stall   = STALL_IF;
            w_src_vld = 1'b1;
            w_src     = SRC_IF;
          end
        end
        FLUSH_WAIT: begin
          // Pipe is empty here, so only the fetch side matters
          if (stallreq_if) w_stall = STALL_IF;
          else             w_state_nxt = RUN;
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_nxt;
  end

  assign stall  = w_stall;
  assign flush  = w_flush;
  assign new_pc = w_new_pc;

  stall_watchdog #(
    .TIMEOUT_W    (TIMEOUT_W),
    .TIMEOUT_LIMIT(TIMEOUT_LIMIT)
  ) u_watchdog (
    .clk           (clk),
    .rst           (rst),
    .i_stall_active(w_stall != STALL_NONE),
    .i_flush       (w_flush),
    .o_timeout     (stall_timeout)
  );

`ifdef PIPE_PERF_EN
  logic [PERF_W-1:0] r_perf [4];
  logic [PERF_W-1:0] r_perf_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_perf[i] <= '0;
      r_perf_cnt <= '0;
    end else begin
      r_perf_cnt <= r_perf[perf_sel];
      if (w_src_vld && (r_perf[w_src] != '1)) begin
        r_perf[w_src] <= r_perf[w_src] + 1'b1;
      end
    end
  end

  assign perf_cnt = r_perf_cnt;
`else
  logic w_unused_perf;
  assign w_unused_perf = ^{perf_sel, w_src_vld, w_src};
  assign perf_cnt      = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: directed scenarios plus random traffic
// compared against a cycle-level behavioural model.
module tb_pipe_stall_ctrl;

  localparam int          LIMIT   = 4;
  localparam logic [31:0] EXCV    = 32'h00000020;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sif = 1'b0, sid = 1'b0, sex = 1'b0, smem = 1'b0;
  logic [31:0] exc = 32'h0, epc = 32'h0;
  logic [1:0]  sel = 2'd0;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        tmo;
  logic [31:0] perf;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(
    .TIMEOUT_W    (16),
    .TIMEOUT_LIMIT(16'd4),
    .EXC_VEC      (EXCV),
    .PERF_W       (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_if  (sif),
    .stallreq_id  (sid),
    .stallreq_ex  (sex),
    .stallreq_mem (smem),
    .excepttype_i (exc),
    .cp0_epc_i    (epc),
    .perf_sel     (sel),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .stall_timeout(tmo),
    .perf_cnt     (perf)
  );

  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        tmo;
    logic [31:0] perf;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Behavioural model: "waiting for fetch" flag, stall-run length, sticky flag, counters
  bit     m_wait   = 0;
  int     m_wd     = 0;
  bit     m_sticky = 0;
  longint m_cnt[4];
  longint m_perf_out = 0;
  int     cur_src;

  bit         p_rst = 1;
  exp_t       p_exp;
  bit         p_if  = 0;
  int         p_src = -1;
  logic [1:0] p_sel = 2'd0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask

  function automatic void model_edge();
    if (p_rst) begin
      m_wait = 0; m_wd = 0; m_sticky = 0; m_perf_out = 0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end else begin
      m_perf_out = m_cnt[p_sel];
      if (p_src >= 0 && m_cnt[p_src] != 64'hFFFFFFFF) m_cnt[p_src] = m_cnt[p_src] + 1;
      if (p_exp.stall != 0) begin
        if (m_wd != 65535) m_wd = m_wd + 1;
        if (m_wd == LIMIT) m_sticky = 1;
      end else begin
        m_wd = 0;
      end
      if (!m_wait) begin
        if (p_exp.flush && p_if) m_wait = 1;
      end else if (!p_if) begin
        m_wait = 0;
      end
    end
  endfunction

  function automatic exp_t model_comb();
    exp_t e;
    int   nxt;
    e = '0;
    cur_src = -1;
    if (!rst) begin
      if (m_wait) begin
        e.stall = sif ? 6'b000011 : 6'b000000;
      end else if (exc != 32'h0) begin
        e.flush = 1'b1;
        e.pc    = (exc == 32'h0000000e) ? epc : EXCV;
      end else if (smem) begin
        e.stall = 6'b011111; cur_src = 3;
      end else if (sex) begin
        e.stall = 6'b001111; cur_src = 2;
      end else if (sid) begin
        e.stall = 6'b000111; cur_src = 1;
      end else if (sif) begin
        e.stall = 6'b000011; cur_src = 0;
      end
    end
    nxt   = (m_wd == 65535) ? m_wd : m_wd + 1;
    e.tmo = m_sticky || (e.stall != 0 && nxt == LIMIT);
`ifdef PIPE_PERF_EN
    e.perf = m_perf_out[31:0];
`else
    e.perf = 32'h0;
`endif
    return e;
  endfunction

  task automatic cycle(input bit r, input bit i, input bit d, input bit x, input bit m,
                       input logic [31:0] e, input logic [31:0] pc, input logic [1:0] s);
    exp_t ex;
    @(posedge clk);
    #1;
    model_edge();
    rst = r; sif = i; sid = d; sex = x; smem = m; exc = e; epc = pc; sel = s;
    ex = model_comb();
    q.push_back(ex);
    p_rst = r; p_exp = ex; p_if = i; p_src = cur_src; p_sel = s;
    #1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("sb_stall", {26'h0, stall}, {26'h0, e.stall});
      chk("sb_flush", {31'h0, flush}, {31'h0, e.flush});
      chk("sb_new_pc", new_pc, e.pc);
      chk("sb_timeout", {31'h0, tmo}, {31'h0, e.tmo});
      chk("sb_perf", perf, e.perf);
    end
  end

  initial begin
    logic [31:0] perf_want;
    int          wait_cnt;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    p_exp = '0;

    cycle(1, 0, 0, 0, 0, 32'h0, 32'h0, 2'd0);
    cycle(1, 0, 0, 0, 0, 32'h0, 32'h0, 2'd0);
    cycle(0, 0, 0, 0, 0, 32'h0, 32'h0, 2'd0);
    chk("reset_stall", {26'h0, stall}, 32'h0);
    chk("reset_timeout", {31'h0, tmo}, 32'h0);
    chk("reset_perf", perf, 32'h0);

    cycle(0, 0, 1, 0, 1, 32'h0, 32'h0, 2'd0);
    chk("mem_id_stall", {26'h0, stall}, 32'h1f);
    chk("mem_id_flush", {31'h0, flush}, 32'h0);

    cycle(0, 0, 0, 1, 0, 32'h8, 32'h0, 2'd0);
    chk("exc_flush", {31'h0, flush}, 32'h1);
    chk("exc_stall", {26'h0, stall}, 32'h0);
    chk("exc_vec", new_pc, 32'h20);

    cycle(0, 0, 0, 0, 0, 32'he, 32'h1234, 2'd0);
    chk("eret_flush", {31'h0, flush}, 32'h1);
    chk("eret_pc", new_pc, 32'h1234);

    cycle(0, 1, 0, 0, 0, 32'h8, 32'h0, 2'd0);
    chk("fw_enter_flush", {31'h0, flush}, 32'h1);
    for (int k = 0; k < 3; k++) begin
      cycle(0, 1, (k == 1), (k == 0), 1'b0, (k == 1) ? 32'h8 : 32'h0, 32'h0, 2'd0);
      chk("fw_stall", {26'h0, stall}, 32'h3);
      chk("fw_noflush", {31'h0, flush}, 32'h0);
    end
    cycle(0, 0, 0, 0, 0, 32'h0, 32'h0, 2'd0);
    chk("fw_exit_stall", {26'h0, stall}, 32'h0);
    cycle(0, 0, 1, 0, 0, 32'h0, 32'h0, 2'd0);
    chk("run_again", {26'h0, stall}, 32'h7);

    cycle(1, 0, 0, 0, 0, 32'h0, 32'h0, 2'd0);
    for (int k = 1; k <= 4; k++) begin
      cycle(0, 0, 0, 1, 0, 32'h0, 32'h0, 2'd0);
      chk("wd_timeout", {31'h0, tmo}, (k == 4) ? 32'h1 : 32'h0);
    end
    cycle(0, 0, 0, 0, 0, 32'h0, 32'h0, 2'd0);
    chk("wd_sticky", {31'h0, tmo}, 32'h1);
    cycle(1, 0, 0, 0, 0, 32'h0, 32'h0, 2'd0);
    cycle(0, 0, 0, 0, 0, 32'h0, 32'h0, 2'd0);
    chk("wd_rst_clear", {31'h0, tmo}, 32'h0);

`ifdef PIPE_PERF_EN
    perf_want = 32'd5;
`else
    perf_want = 32'd0;
`endif
    for (int k = 0; k < 5; k++) cycle(0, 0, 1, 0, 0, 32'h0, 32'h0, 2'd0);
    cycle(0, 0, 0, 0, 0, 32'h0, 32'h0, 2'd1);
    cycle(0, 0, 0, 0, 0, 32'h0, 32'h0, 2'd1);
    chk("perf_id", perf, perf_want);
    cycle(1, 0, 0, 0, 0, 32'h0, 32'h0, 2'd1);
    cycle(0, 0, 0, 0, 0, 32'h0, 32'h0, 2'd1);
    chk("perf_rst", perf, 32'h0);

    for (int n = 0; n < 2000; n++) begin
      bit          r, i, d, x, m;
      logic [31:0] e;
      r = ($urandom_range(0, 59) == 0);
      i = ($urandom_range(0, 99) < 40);
      d = ($urandom_range(0, 99) < 25);
      x = ($urandom_range(0, 99) < 20);
      m = ($urandom_range(0, 99) < 15);
      e = 32'h0;
      if ($urandom_range(0, 9) == 0) e = ($urandom_range(0, 2) == 0) ? 32'he : ($urandom | 32'h1);
      cycle(r, i, d, x, m, e, $urandom, 2'($urandom_range(0, 3)));
    end
    cycle(0, 0, 0, 0, 0, 32'h0, 32'h0, 2'd0);

    wait_cnt = 0;
    while (q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    chk("sb_drained", q.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
